combined_mem_master: RTL and testbench

- CPU-side initiator for the single-port combined instruction/data memory.
- The memory reads combinationally, writes on the posedge when write-enable is high, and indexes by addr[8:2].
- Takes one request per instruction (fetch plus an optional load or store), serialises the accesses onto the one memory port with a small FSM, and returns the instruction, load data and a fault code.
- Sits between the processor datapath and combinedMemory.

---
 rtl/combined_mem_pkg.sv | 40 ++++
 rtl/combined_mem_master_if.sv | 39 +++
 rtl/combined_mem_master_addr_check.sv | 27 ++
 rtl/combined_mem_master.sv | 167 ++++++++++++++++
 tb/tb_combined_mem_master.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/combined_mem_pkg.sv
// Shared types and constants for the combined instruction/data memory master.
// Holds the FSM state enum, fault codes, default memory size and the
// latched request payload.
// Optional build macro COMBINED_MEM_STORE_READBACK_EN adds the VERIFY state.
package combined_mem_pkg;

  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned FAULT_W           = 2;
  localparam int unsigned WORD_SHIFT        = 2;
  localparam int unsigned MEM_WORDS_DEFAULT = 64;

  typedef logic [FAULT_W-1:0] fault_t;

  localparam fault_t FAULT_OK       = 2'b00;
  localparam fault_t FAULT_MISALIGN = 2'b01;
  localparam fault_t FAULT_RANGE    = 2'b10;
  localparam fault_t FAULT_READBACK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DATA,
    ST_RESP
`ifdef COMBINED_MEM_STORE_READBACK_EN
    ,
    ST_VERIFY
`endif
  } state_e;

  // Request fields captured at the handshake.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              has_data;
    logic              write;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/combined_mem_master_if.sv
// Bus bundle between CPU datapath, memory master and combinedMemory.
// master: the memory master (takes req_*, drives rsp_* and mem_* strobes).
// slave : the surrounding CPU datapath and memory.
interface combined_mem_master_if;
  import combined_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              req_has_data;
  logic              req_write;
  logic [ADDR_W-1:0] req_daddr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_instr;
  logic [DATA_W-1:0] rsp_rdata;
  fault_t            rsp_fault;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_writeData;
  logic              mem_writeEnable;
  logic [DATA_W-1:0] mem_read;

  modport master (
    input  req_valid, req_pc, req_has_data, req_write, req_daddr, req_wdata,
    input  mem_read,
    output req_ready, rsp_valid, rsp_instr, rsp_rdata, rsp_fault,
    output mem_addr, mem_writeData, mem_writeEnable
  );

  modport slave (
    output req_valid, req_pc, req_has_data, req_write, req_daddr, req_wdata,
    output mem_read,
    input  req_ready, rsp_valid, rsp_instr, rsp_rdata, rsp_fault,
    input  mem_addr, mem_writeData, mem_writeEnable
  );

endinterface

// File: rtl/combined_mem_master_addr_check.sv
// mem_addr_check: combinational address fault classifier.
// Ports: addr_i (byte address), mem_words_i (backed words),
//        fault_o (OK / MISALIGN / RANGE, misalignment takes priority).
module mem_addr_check
  import combined_mem_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] mem_words_i,
  output fault_t            fault_o
);

  localparam int unsigned LIM_W = ADDR_W + WORD_SHIFT;

  // Byte limit kept wide so large word counts cannot wrap.
  logic [LIM_W-1:0] limit;
  assign limit = {mem_words_i, {WORD_SHIFT{1'b0}}};

  always_comb begin
    fault_o = FAULT_OK;
    if (addr_i[WORD_SHIFT-1:0] != '0) begin
      fault_o = FAULT_MISALIGN;
    end else if (LIM_W'(addr_i) >= limit) begin
      fault_o = FAULT_RANGE;
    end
  end

endmodule

// File: rtl/combined_mem_master.sv
// combined_mem_master: serialises an instruction fetch plus an optional load
// or store onto the single combined memory port and returns instruction,
// load data and a fault code.
// Ports: clk, reset (async, active-high), bus (combined_mem_master_if.master:
//        req_* handshake in, rsp_* response out, mem_* memory port).
// Macro COMBINED_MEM_STORE_READBACK_EN: re-reads each store in a VERIFY
// state and reports FAULT_READBACK on mismatch.
module combined_mem_master
  import combined_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS     = MEM_WORDS_DEFAULT,
  parameter int unsigned RESET_PC_WORD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  combined_mem_master_if.master bus
);

  localparam logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(RESET_PC_WORD) << WORD_SHIFT;

  state_e            state_q, state_d;
  req_t              req_q;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  fault_t            fault_q, fault_d;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_instr_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  fault_t            rsp_fault_q;

  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              mem_we_c;

  fault_t            pc_fault;
  fault_t            d_fault;

  mem_addr_check u_pc_check (
    .addr_i      (req_q.pc),
    .mem_words_i (ADDR_W'(MEM_WORDS)),
    .fault_o     (pc_fault)
  );

  mem_addr_check u_daddr_check (
    .addr_i      (req_q.daddr),
    .mem_words_i (ADDR_W'(MEM_WORDS)),
    .fault_o     (d_fault)
  );

  // Next state, working results and memory port decode.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    mem_addr_c  = IDLE_ADDR;
    mem_wdata_c = '0;
    mem_we_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          instr_d = '0;
          rdata_d = '0;
          fault_d = FAULT_OK;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_addr_c = req_q.pc;
        if (pc_fault != FAULT_OK) begin
          fault_d = pc_fault;
          instr_d = '0;
          state_d = ST_RESP;
        end else begin
          instr_d = bus.mem_read;
          state_d = req_q.has_data ? ST_DATA : ST_RESP;
        end
      end

      ST_DATA: begin
        mem_addr_c = req_q.daddr;
        if (d_fault != FAULT_OK) begin
          fault_d = d_fault;
          rdata_d = '0;
          state_d = ST_RESP;
        end else if (req_q.write) begin
          mem_wdata_c = req_q.wdata;
          mem_we_c    = 1'b1;
          rdata_d     = '0;
`ifdef COMBINED_MEM_STORE_READBACK_EN
          state_d     = ST_VERIFY;
`else
          state_d     = ST_RESP;
`endif
        end else begin
          rdata_d = bus.mem_read;
          state_d = ST_RESP;
        end
      end

`ifdef COMBINED_MEM_STORE_READBACK_EN
      ST_VERIFY: begin
        mem_addr_c = req_q.daddr;
        if (bus.mem_read != req_q.wdata) begin
          fault_d = FAULT_READBACK;
        end
        state_d = ST_RESP;
      end
`endif

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request latch and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
      fault_q     <= FAULT_OK;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= FAULT_OK;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (state_q == ST_IDLE && bus.req_valid) begin
        req_q.pc       <= bus.req_pc;
        req_q.has_data <= bus.req_has_data;
        req_q.write    <= bus.req_write & bus.req_has_data;
        req_q.daddr    <= bus.req_daddr;
        req_q.wdata    <= bus.req_wdata;
      end
      // Response fields only move when a response is issued.
      rsp_valid_q <= (state_d == ST_RESP);
      if (state_d == ST_RESP) begin
        rsp_instr_q <= instr_d;
        rsp_rdata_q <= rdata_d;
        rsp_fault_q <= fault_d;
      end
    end
  end

  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_instr       = rsp_instr_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_fault       = rsp_fault_q;
  assign bus.mem_addr        = mem_addr_c;
  assign bus.mem_writeData   = mem_wdata_c;
  assign bus.mem_writeEnable = mem_we_c;

endmodule

// File: tb/tb_combined_mem_master.sv
// Testbench for combined_mem_master: behavioural memory, directed boundary
// cases, reset during a store, back-to-back requests, then random requests
// checked against a transaction-level reference model.
module tb_combined_mem_master;

  localparam int unsigned MW = 64;
`ifdef COMBINED_MEM_STORE_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  combined_mem_master_if bus();

  combined_mem_master #(.MEM_WORDS(MW), .RESET_PC_WORD(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory: combinational read, posedge write, indexed by addr[8:2].
  logic [31:0] mem       [128];
  logic [31:0] seed_mem  [128];
  logic [31:0] model_mem [128];
  logic        preload;

  assign bus.mem_read = mem[bus.mem_addr[8:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= seed_mem[i];
    end else if (bus.mem_writeEnable) begin
      mem[bus.mem_addr[8:2]] <= bus.mem_writeData;
    end
  end

  int          cyc = 0;
  int          we_count = 0;
  logic [31:0] last_we_addr = '0;
  int          accept_cnt = 0;
  int          last_acc = 0;
  int          prev_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_writeEnable) begin
      we_count     <= we_count + 1;
      last_we_addr <= bus.mem_addr;
    end
    if (bus.req_valid && bus.req_ready && !reset) begin
      accept_cnt <= accept_cnt + 1;
      prev_acc   <= last_acc;
      last_acc   <= cyc;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Fault rule: misaligned beats out-of-range; limit is MW words.
  function automatic logic [1:0] addr_fault(input logic [31:0] a);
    if (a % 4 != 0) return 2'd1;
    if (a >= MW * 4) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
    if (k == 1) return $urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'(4 * $urandom_range(64, 255));
    return 32'(4 * $urandom_range(0, 63));
  endfunction

  // One complete request: drive, measure latency, compare with the model.
  task automatic do_req(input string tag, input logic [31:0] pc, input logic hd,
                        input logic wr, input logic [31:0] da, input logic [31:0] wd);
    logic [31:0] e_instr, e_rdata;
    logic [1:0]  e_fault, pf, df;
    int          e_lat, e_wr, lat, we0;

    e_instr = '0; e_rdata = '0; e_fault = 2'd0; e_lat = 2; e_wr = 0;
    pf = addr_fault(pc);
    if (pf != 2'd0) begin
      e_fault = pf;
    end else begin
      e_instr = model_mem[pc / 4];
      if (hd) begin
        e_lat = 3;
        df = addr_fault(da);
        if (df != 2'd0) begin
          e_fault = df;
        end else if (wr) begin
          e_wr  = 1;
          e_lat = 3 + RB;
          model_mem[da / 4] = wd;
        end else begin
          e_rdata = model_mem[da / 4];
        end
      end
    end

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_pc       = pc;
    bus.req_has_data = hd;
    bus.req_write    = wr;
    bus.req_daddr    = da;
    bus.req_wdata    = wd;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    we0 = we_count;
    @(posedge clk);
    @(negedge clk);
    // Garbage on the request lines must not disturb the transaction.
    bus.req_valid    = 1'b0;
    bus.req_pc       = $urandom;
    bus.req_has_data = 1'($urandom);
    bus.req_write    = 1'($urandom);
    bus.req_daddr    = $urandom;
    bus.req_wdata    = $urandom;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_instr"}, bus.rsp_instr, e_instr);
    chk({tag, "_rdata"}, bus.rsp_rdata, e_rdata);
    chk({tag, "_fault"}, 32'(bus.rsp_fault), 32'(e_fault));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_hold"}, bus.rsp_instr, e_instr);
    chk({tag, "_writes"}, 32'(we_count - we0), 32'(e_wr));
    if (e_wr != 0) chk({tag, "_waddr"}, last_we_addr, da);
  endtask

  logic [31:0] r_instr [2];
  int          nresp;
  int          acc0;

  initial begin
    bus.req_valid = 1'b0; bus.req_pc = '0; bus.req_has_data = 1'b0;
    bus.req_write = 1'b0; bus.req_daddr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 128; i++) seed_mem[i] = $urandom;
    seed_mem[0]  = 32'h8C01_0088;
    seed_mem[32] = 32'd12;
    seed_mem[37] = 32'd0;
    for (int i = 0; i < 128; i++) model_mem[i] = seed_mem[i];
    reset   = 1'b1;
    preload = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    reset   = 1'b0;

    // Reset state.
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_instr", bus.rsp_instr, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst_we", 32'(bus.mem_writeEnable), 32'd0);
    chk("rst_wdata", bus.mem_writeData, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);

    // Directed cases.
    do_req("fetch0", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_req("load80", 32'h4, 1'b1, 1'b0, 32'h80, 32'h0);
    do_req("store90", 32'h8, 1'b1, 1'b1, 32'h90, 32'd15);
    do_req("load90", 32'hC, 1'b1, 1'b0, 32'h90, 32'h0);
    do_req("load81", 32'h10, 1'b1, 1'b0, 32'h81, 32'h0);
    do_req("pc100", 32'h100, 1'b1, 1'b1, 32'h94, 32'd5);
    do_req("pcFFFC", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);
    do_req("pcmis", 32'h2, 1'b1, 1'b0, 32'h400, 32'h0);
    do_req("dmis", 32'h14, 1'b1, 1'b1, 32'h101, 32'd7);
    do_req("drange", 32'h18, 1'b1, 1'b1, 32'h100, 32'd7);

    // Reset during the DATA cycle of a store aborts the write.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_pc = 32'h1C; bus.req_has_data = 1'b1;
    bus.req_write = 1'b1; bus.req_daddr = 32'h94; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_we_before", 32'(bus.mem_writeEnable), 32'd1);
    chk("abort_addr_before", bus.mem_addr, 32'h94);
    reset = 1'b1;
    #1;
    chk("abort_we", 32'(bus.mem_writeEnable), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_word37", mem[37], 32'd0);
    do_req("load94", 32'h0, 1'b1, 1'b0, 32'h94, 32'h0);

    // Back-to-back fetches with req_valid held high.
    acc0  = accept_cnt;
    nresp = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_pc = 32'h0; bus.req_has_data = 1'b0;
    bus.req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_pc = 32'h4;
    for (int k = 0; k < 12 && nresp < 2; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        r_instr[nresp] = bus.rsp_instr;
        nresp++;
      end
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_nresp", 32'(nresp), 32'd2);
    chk("b2b_accepts", 32'(accept_cnt - acc0), 32'd2);
    chk("b2b_spacing", 32'(last_acc - prev_acc), 32'd3);
    chk("b2b_instr0", r_instr[0], model_mem[0]);
    chk("b2b_instr1", r_instr[1], model_mem[1]);

    // Random requests against the model.
    for (int n = 0; n < 40; n++) begin
      do_req("rand", rand_addr(), 1'($urandom), 1'($urandom), rand_addr(), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
